card_shoe: RTL and testbench

- Card source that answers card requests from the blackjack game FSM. It is the responder side of a request/deliver handshake.
- Models a single 52-card deck. No card repeats until the deck is reshuffled.
- Each delivered card carries its deck index, rank and blackjack value.
- Replaces the free-running random card value path. The game FSM asserts a request and waits for the valid pulse before scoring.

---
 rtl/blackjack_pkg.sv | 27 ++
 rtl/card_lfsr.sv | 24 ++
 rtl/card_shoe.sv | 143 ++++++++++++++
 tb/tb_card_shoe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// Shared types and constants for the blackjack card path: shoe state encoding,
// deck geometry and the card LFSR step function.
package blackjack_pkg;

    localparam int DECK_CARDS = 52;
    localparam int RANKS      = 13;
    localparam int FACE_VALUE = 10;

    localparam int IDX_W   = 6;
    localparam int RANK_W  = 4;
    localparam int VALUE_W = 4;
    localparam int LFSR_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_PICK,
        S_PROBE,
        S_DELIVER
    } shoe_state_t;

    // Fibonacci step for x^8+x^6+x^5+x^4+1 (maximal length, period 255)
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 8-bit LFSR used as the card candidate source; reloads SEED on reset.
module card_lfsr
    import blackjack_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic [LFSR_W-1:0] o_lfsr
);

    logic [LFSR_W-1:0] r_lfsr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/card_shoe.sv
// Single-deck card shoe: answers card requests with a non-repeating card
// drawn by LFSR candidate plus linear probe over the dealt bitmap.
module card_shoe
    import blackjack_pkg::*;
#(
    parameter int          DECK_CARDS     = 52,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5,
    parameter bit          AUTO_RESHUFFLE = 1'b1
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         card_req,
    input  logic         shuffle,
    output logic         card_ready,
    output logic         card_valid,
    output logic [5:0]   card_index,
    output logic [3:0]   card_rank,
    output logic [3:0]   card_value,
    output logic [5:0]   cards_left,
    output logic         reshuffled
);

    logic [LFSR_W-1:0]     w_lfsr;
    logic [1:0]            w_unused_lfsr_hi;
    logic [IDX_W-1:0]      w_cand;
    logic [IDX_W-1:0]      w_rem;
    logic [RANK_W-1:0]     w_rank;
    logic [VALUE_W-1:0]    w_value;
    logic                  w_ready;

    shoe_state_t           r_state;
    logic [DECK_CARDS-1:0] r_dealt;
    logic [IDX_W-1:0]      r_left;
    logic [IDX_W-1:0]      r_ptr;
    logic                  r_pending;
    logic                  r_valid;
    logic [IDX_W-1:0]      r_idx;
    logic [RANK_W-1:0]     r_rank;
    logic [VALUE_W-1:0]    r_value;
    logic                  r_resh;

    card_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clk  (CLOCK_50),
        .i_rst  (reset),
        .o_lfsr (w_lfsr)
    );

    assign w_unused_lfsr_hi = w_lfsr[7:6];

    // Fold the 6-bit candidate 52..63 back onto 0..11
    assign w_cand = (w_lfsr[5:0] >= 6'(DECK_CARDS)) ? (w_lfsr[5:0] - 6'(DECK_CARDS))
                                                    : w_lfsr[5:0];

    always_comb begin
        w_rem = r_ptr;
        if (r_ptr >= 6'(3 * RANKS)) begin
            w_rem = r_ptr - 6'(3 * RANKS);
        end else if (r_ptr >= 6'(2 * RANKS)) begin
            w_rem = r_ptr - 6'(2 * RANKS);
        end else if (r_ptr >= 6'(RANKS)) begin
            w_rem = r_ptr - 6'(RANKS);
        end
        w_rank  = 4'(w_rem + 6'd1);
        w_value = (w_rank >= 4'(FACE_VALUE)) ? 4'(FACE_VALUE) : w_rank;
    end

    assign w_ready = (r_state == S_IDLE) && !shuffle &&
                     ((r_left != '0) || AUTO_RESHUFFLE);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_dealt   <= '0;
            r_left    <= 6'(DECK_CARDS);
            r_ptr     <= '0;
            r_pending <= 1'b0;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_rank    <= '0;
            r_value   <= '0;
            r_resh    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_resh  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (shuffle) begin
                        r_pending <= 1'b0;
                        r_state   <= S_CLEAR;
                    end else if (card_req && w_ready) begin
                        if (r_left == '0) begin
                            r_pending <= 1'b1;
                            r_state   <= S_CLEAR;
                        end else begin
                            r_state <= S_PICK;
                        end
                    end
                end
                S_CLEAR: begin
                    r_dealt   <= '0;
                    r_left    <= 6'(DECK_CARDS);
                    r_resh    <= 1'b1;
                    r_pending <= 1'b0;
                    r_state   <= r_pending ? S_PICK : S_IDLE;
                end
                S_PICK: begin
                    r_ptr   <= w_cand;
                    r_state <= S_PROBE;
                end
                S_PROBE: begin
                    if (!r_dealt[r_ptr]) begin
                        r_dealt[r_ptr] <= 1'b1;
                        r_left         <= r_left - 6'd1;
                        r_idx          <= r_ptr;
                        r_rank         <= w_rank;
                        r_value        <= w_value;
                        r_valid        <= 1'b1;
                        r_state        <= S_DELIVER;
                    end else begin
                        r_ptr <= (r_ptr == 6'(DECK_CARDS - 1)) ? '0 : (r_ptr + 6'd1);
                    end
                end
                S_DELIVER: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign card_ready = w_ready;
    assign card_valid = r_valid;
    assign card_index = r_idx;
    assign card_rank  = r_rank;
    assign card_value = r_value;
    assign cards_left = r_left;
    assign reshuffled = r_resh;

endmodule

// File: tb/tb_card_shoe.sv
// Scoreboard bench for card_shoe: stimulus predicts each card from an
// independent LFSR/bitmap model; a negedge monitor pops and compares.
module tb_card_shoe;

    logic       clk = 1'b0;
    logic       rst;
    logic       req, shf;
    logic       ready, valid, resh;
    logic [5:0] idx, left;
    logic [3:0] rank, value;

    logic       req0, shf0;
    logic       ready0, valid0, resh0;
    logic [5:0] idx0, left0;
    logic [3:0] rank0, value0;

    always #5 clk = ~clk;

    card_shoe #(.AUTO_RESHUFFLE(1'b1)) dut (
        .CLOCK_50(clk), .reset(rst), .card_req(req), .shuffle(shf),
        .card_ready(ready), .card_valid(valid), .card_index(idx),
        .card_rank(rank), .card_value(value), .cards_left(left),
        .reshuffled(resh)
    );

    card_shoe #(.AUTO_RESHUFFLE(1'b0)) dut0 (
        .CLOCK_50(clk), .reset(rst), .card_req(req0), .shuffle(shf0),
        .card_ready(ready0), .card_valid(valid0), .card_index(idx0),
        .card_rank(rank0), .card_value(value0), .cards_left(left0),
        .reshuffled(resh0)
    );

    typedef struct {
        int idx;
        int left;
        int cyc;
        int acc;
        int rs;
    } exp_t;

    exp_t       q[$];
    int         got_idx[$];
    int         total, bad;
    int         cyc;
    int         rs_cnt;
    int         m_left;
    bit [51:0]  m_dealt;
    bit [51:0]  seen;
    logic [7:0] tb_l;

    function automatic logic [7:0] step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic int cand(input logic [7:0] l);
        int c;
        c = int'(l[5:0]);
        if (c >= 52) c = c - 52;
        return c;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc  <= 0;
            tb_l <= 8'hA5;
        end else begin
            cyc  <= cyc + 1;
            tb_l <= step(tb_l);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        int   r, lat;
        if (resh) rs_cnt++;
        if (!rst && valid) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = q.pop_front();
                r = (e.idx % 13) + 1;
                lat = cyc - e.acc + 1;
                check("index", int'(idx), e.idx);
                check("rank", int'(rank), r);
                check("value", int'(value), (r >= 10) ? 10 : r);
                check("cards_left", int'(left), e.left);
                check("arrival_cycle", cyc, e.cyc);
                check("latency_bound", int'(lat >= 3 && lat <= 54 + e.rs), 1);
                got_idx.push_back(int'(idx));
                if (idx < 6'd52) seen[idx] = 1'b1;
            end
        end
    end

    // Caller is at a negedge; the accept edge is the next posedge.
    task automatic do_req();
        exp_t       e;
        logic [7:0] l;
        int         t, p, n, rs;
        t = 0;
        while (!ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ready) begin
            check("req_ready_timeout", 0, 1);
            return;
        end
        rs = 0;
        l  = step(tb_l);
        if (m_left == 0) begin
            rs      = 1;
            m_dealt = '0;
            m_left  = 52;
            l       = step(l);
        end
        p = cand(l);
        n = 1;
        while (m_dealt[p]) begin
            p = (p == 51) ? 0 : p + 1;
            n++;
        end
        m_dealt[p] = 1'b1;
        m_left--;
        e.idx  = p;
        e.left = m_left;
        e.acc  = cyc + 1;
        e.cyc  = cyc + 1 + 2 + (n - 1) + rs;
        e.rs   = rs;
        q.push_back(e);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            check("drain_timeout", q.size(), 0);
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0, k, cnt, t;
        bit ok;
        rst = 1'b1; req = 1'b0; shf = 1'b0; req0 = 1'b0; shf0 = 1'b0;
        total = 0; bad = 0; rs_cnt = 0;
        m_dealt = '0; m_left = 52; seen = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_ready", int'(ready), 1);
        check("rst_valid", int'(valid), 0);
        check("rst_index", int'(idx), 0);
        check("rst_rank", int'(rank), 0);
        check("rst_value", int'(value), 0);
        check("rst_left", int'(left), 52);
        check("rst_reshuffled", int'(resh), 0);

        for (int i = 0; i < 52; i++) do_req();
        wait_drain();
        check("distinct_cover", $countones(seen), 52);
        check("left_after_52", int'(left), 0);
        check("ready_empty_auto", int'(ready), 1);

        r0 = rs_cnt;
        do_req();
        wait_drain();
        check("auto_reshuffle_pulses", rs_cnt - r0, 1);
        check("left_after_auto", int'(left), 51);

        for (int i = 0; i < 9; i++) do_req();
        wait_drain();
        check("left_after_10", int'(left), 42);
        t = 0;
        while (!ready && t < 100) begin @(negedge clk); t++; end
        r0 = rs_cnt;
        shf = 1'b1; req = 1'b1;
        @(negedge clk);
        shf = 1'b0; req = 1'b0;
        m_dealt = '0; m_left = 52;
        repeat (4) @(negedge clk);
        check("shuffle_pulses", rs_cnt - r0, 1);
        check("left_after_shuffle", int'(left), 52);
        check("ready_after_shuffle", int'(ready), 1);

        do_req();
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_drain();
        check("busy_req_left", int'(left), 51);

        do_req();
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        m_dealt = '0; m_left = 52;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("abort_ready", int'(ready), 1);
        check("abort_left", int'(left), 52);
        check("abort_valid", int'(valid), 0);
        k = got_idx.size();
        for (int i = 0; i < 3; i++) do_req();
        wait_drain();
        for (int i = 0; i < 3; i++) begin
            if (got_idx.size() > k + i) check("repro_index", got_idx[k + i], got_idx[i]);
            else check("repro_missing", 0, 1);
        end

        cnt = 0;
        for (int i = 0; i < 52; i++) begin
            t = 0;
            while (!ready0 && t < 100) begin @(negedge clk); t++; end
            req0 = 1'b1;
            @(negedge clk);
            req0 = 1'b0;
            t = 0;
            while (!valid0 && t < 60) begin @(negedge clk); t++; end
            if (valid0) cnt++;
            @(negedge clk);
        end
        check("noauto_cards", cnt, 52);
        check("noauto_left", int'(left0), 0);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (ready0) ok = 1'b0;
            @(negedge clk);
        end
        check("noauto_ready_low", int'(ok), 1);
        req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (valid0) cnt++;
            @(negedge clk);
        end
        check("noauto_refused", cnt, 0);
        shf0 = 1'b1;
        @(negedge clk);
        shf0 = 1'b0;
        repeat (3) @(negedge clk);
        check("noauto_shuffle_ready", int'(ready0), 1);
        check("noauto_shuffle_left", int'(left0), 52);

        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
